// File: rtl/tx_stream_buffer.sv
// Buffered transmit channel: a DEPTH-entry word FIFO that drains onto txdata/txclk
// using a setup/strobe/hold handshake paced by the sink's txready.
module tx_stream_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_ovf,
  input  logic             txready,
  output logic [WIDTH-1:0] txdata,
  output logic             txclk,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] txdata_q;
  logic             txclk_q;
  logic             full_c, empty_c, pop_c, push_c, drop_c;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  // Pop only when the handshake is at a word boundary; a full FIFO still
  // accepts a write on the edge that frees a slot.
  always_comb begin
    pop_c    = 1'b0;
    push_c   = 1'b0;
    drop_c   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if ((state_q == IDLE || state_q == HOLD) && txready && !empty_c) begin
      pop_c = 1'b1;
    end
    push_c = wr_en && (!full_c || pop_c);
    drop_c = wr_en && full_c && !pop_c;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge hz100) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake sequencer; txready is only looked at on word boundaries.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      txdata_q <= '0;
      txclk_q  <= 1'b0;
    end else begin
      txclk_q <= 1'b0;
      case (state_q)
        IDLE, HOLD: begin
          if (pop_c) begin
            state_q  <= SETUP;
            txdata_q <= mem_q[rd_ptr_q];
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          state_q <= STROBE;
          txclk_q <= 1'b1;
        end
        STROBE:  state_q <= HOLD;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txdata   = txdata_q;
  assign txclk    = txclk_q;
  assign full     = full_c;
  assign empty    = empty_c;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_tx_stream_buffer.sv
// Bench for tx_stream_buffer: queue-based reference model for the 8x16 instance,
// plus an in-order stream scoreboard for a 12x4 instance.
module tb_tx_stream_buffer;

  localparam int unsigned W0 = 8;
  localparam int unsigned D0 = 16;
  localparam int unsigned W1 = 12;
  localparam int unsigned D1 = 4;

  logic clk = 1'b0;
  logic rst;

  logic          wr_en, clr_ovf, txready;
  logic [W0-1:0] wr_data, txdata;
  logic          txclk, full, empty, overflow;
  logic [4:0]    count;

  logic          w1_en, txready1;
  logic [W1-1:0] w1_data, txdata1;
  logic          txclk1, full1, empty1, ovf1;
  logic [2:0]    count1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tx_stream_buffer #(.WIDTH(W0), .DEPTH(D0)) dut0 (
    .hz100(clk), .reset(rst), .wr_en(wr_en), .wr_data(wr_data),
    .clr_ovf(clr_ovf), .txready(txready), .txdata(txdata), .txclk(txclk),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  tx_stream_buffer #(.WIDTH(W1), .DEPTH(D1)) dut1 (
    .hz100(clk), .reset(rst), .wr_en(w1_en), .wr_data(w1_data),
    .clr_ovf(1'b0), .txready(txready1), .txdata(txdata1), .txclk(txclk1),
    .full(full1), .empty(empty1), .count(count1), .overflow(ovf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending words plus cycles left in the current transfer
  // (3 = setup, 2 = strobe, 1 = hold, 0 = nothing in flight).
  logic [W0-1:0] mq[$];
  int            m_busy = 0;
  logic [W0-1:0] m_txdata = '0;
  logic          m_ovf = 1'b0;
  logic [W0-1:0] log0[$];

  task automatic model_step();
    bit pop_now, full_now;
    if (rst) begin
      mq.delete();
      m_busy   = 0;
      m_txdata = '0;
      m_ovf    = 1'b0;
      return;
    end
    full_now = (mq.size() == D0);
    pop_now  = (m_busy <= 1) && txready && (mq.size() > 0);
    if (wr_en && full_now && !pop_now) m_ovf = 1'b1;
    else if (clr_ovf)                  m_ovf = 1'b0;
    if (pop_now) begin
      m_txdata = mq.pop_front();
      m_busy   = 3;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    if (wr_en && (!full_now || pop_now)) mq.push_back(wr_data);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Every-cycle comparison of dut0 against the model; also logs strobed words.
  initial forever begin
    @(negedge clk);
    check("txdata",   32'(txdata),   32'(m_txdata));
    check("txclk",    32'(txclk),    32'(m_busy == 2));
    check("count",    32'(count),    32'(mq.size()));
    check("full",     32'(full),     32'(mq.size() == D0));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (txclk) log0.push_back(txdata);
  end

  // In-order scoreboard for dut1.
  logic [W1-1:0] sent1[$];
  int            got1 = 0;

  initial forever begin
    @(negedge clk);
    if (txclk1) begin
      if (sent1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wrap_extra: got %0h expected no strobe", txdata1);
      end else begin
        check("wrap_data", 32'(txdata1), 32'(sent1.pop_front()));
        got1++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic write0(input logic [W0-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < log0.size()) return 32'(log0[i]);
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int step, budget;
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0; txready = 1'b0;
    w1_en = 1'b0; w1_data = '0; txready1 = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_txdata", 32'(txdata), 32'h0);
    check("rst_txclk",  32'(txclk),  32'h0);
    check("rst_count",  32'(count),  32'h0);
    check("rst_empty",  32'(empty),  32'h1);
    check("rst_full",   32'(full),   32'h0);
    check("rst_ovf",    32'(overflow), 32'h0);

    // Single word latency
    txready = 1'b1;
    write0(8'hA5);
    check("single_cnt1", 32'(count), 32'h1);
    @(negedge clk);
    check("single_setup_data", 32'(txdata), 32'hA5);
    check("single_setup_clk",  32'(txclk),  32'h0);
    @(negedge clk);
    check("single_strobe_clk",  32'(txclk),  32'h1);
    check("single_strobe_data", 32'(txdata), 32'hA5);
    @(negedge clk);
    check("single_hold_clk",  32'(txclk),  32'h0);
    check("single_hold_data", 32'(txdata), 32'hA5);
    @(negedge clk);
    check("single_cnt0",     32'(count),  32'h0);
    check("single_idle_data", 32'(txdata), 32'hA5);

    // Fill past full
    txready = 1'b0;
    log0.delete();
    for (int i = 0; i < 17; i++) write0(8'(i));
    check("fill_count", 32'(count),    32'd16);
    check("fill_full",  32'(full),     32'h1);
    check("fill_ovf",   32'(overflow), 32'h1);
    txready = 1'b1;
    repeat (16 * 3 + 4) @(negedge clk);
    check("fill_nwords", 32'(log0.size()), 32'd16);
    for (int i = 0; i < 16; i++) check("fill_order", log_at(i), 32'(i));
    check("fill_ovf_sticky", 32'(overflow), 32'h1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("fill_ovf_clr", 32'(overflow), 32'h0);

    // Full FIFO with a write on the popping edge
    txready = 1'b0;
    log0.delete();
    for (int i = 0; i < 16; i++) write0(8'(32'h20 + i));
    check("fp_full", 32'(full), 32'h1);
    txready = 1'b1;
    @(negedge clk);
    write0(8'h30);
    @(negedge clk);
    check("fp_full_hold", 32'(full), 32'h1);
    write0(8'h55);
    check("fp_count", 32'(count),    32'd16);
    check("fp_ovf",   32'(overflow), 32'h0);
    repeat (17 * 3 + 4) @(negedge clk);
    check("fp_nwords", 32'(log0.size()), 32'd18);
    check("fp_w30",    log_at(16), 32'h30);
    check("fp_last",   log_at(17), 32'h55);

    // Backpressure during the first strobe
    txready = 1'b0;
    log0.delete();
    for (int i = 0; i < 4; i++) write0(8'(32'h61 + i));
    txready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_strobe", 32'(txclk),  32'h1);
    check("bp_data",   32'(txdata), 32'h61);
    txready = 1'b0;
    repeat (10) @(negedge clk);
    check("bp_stalled", 32'(log0.size()), 32'd1);
    check("bp_count",   32'(count),       32'd3);
    txready = 1'b1;
    repeat (14) @(negedge clk);
    check("bp_nwords", 32'(log0.size()), 32'd4);
    for (int i = 1; i < 4; i++) check("bp_order", log_at(i), 32'(32'h61 + i));

    // Reset in the middle of a strobe
    txready = 1'b0;
    log0.delete();
    write0(8'h71);
    write0(8'h72);
    txready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mr_strobe", 32'(txclk), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mr_txclk",  32'(txclk),  32'h0);
    check("mr_count",  32'(count),  32'h0);
    check("mr_txdata", 32'(txdata), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mr_no_strobe", 32'(log0.size()), 32'd1);
    write0(8'h7A);
    repeat (5) @(negedge clk);
    check("mr_new_n",    32'(log0.size()), 32'd2);
    check("mr_new_word", log_at(1), 32'h7A);

    // Pointer wrap on the 12x4 instance with interleaved writes and backpressure
    step = 0;
    for (int i = 0; i < 40; i++) begin
      budget = 0;
      while (full1 && budget < 50) begin
        txready1 = (step % 5 != 4);
        step++;
        budget++;
        @(negedge clk);
      end
      if (budget >= 50) begin
        n_vec++;
        n_err++;
        $display("FAIL wrap_full_stuck: got full expected space");
      end
      w1_en   = 1'b1;
      w1_data = 12'(32'h800 + i * 37);
      sent1.push_back(w1_data);
      txready1 = (step % 5 != 4);
      step++;
      @(negedge clk);
      w1_en = 1'b0;
      for (int k = 0; k < i % 3; k++) begin
        txready1 = (step % 5 != 4);
        step++;
        @(negedge clk);
      end
    end
    txready1 = 1'b1;
    budget = 0;
    while (sent1.size() != 0 && budget < 100) begin
      budget++;
      @(negedge clk);
    end
    check("wrap_count", 32'(got1), 32'd40);
    check("wrap_ovf",   32'(ovf1), 32'h0);
    check("wrap_empty", 32'(empty1), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_stream_buffer.md
Name: tx_stream_buffer

Overview:
- Parametrised successor to the single-byte transmit interface between user logic and the board-level txdata/txclk/txready channel.
- Accepts words from user logic into a DEPTH-entry FIFO and serialises them onto the outgoing channel.
- Drives a setup/strobe/hold sequence on txdata/txclk, paced by the sink's txready.
- Adds buffering, configurable word width, occupancy reporting and a sticky overflow flag, none of which exist on the bare interface.

Parameters:
- WIDTH, 8, data word width in bits (1..32).
- DEPTH, 16, FIFO depth in entries; must be a power of two, minimum 2.
- CW, $clog2(DEPTH+1), width of count output; derived, not overridden.

Ports:
- hz100  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  push wr_data this cycle.
- wr_data  input  WIDTH  word to enqueue.
- clr_ovf  input  1  synchronous clear of overflow.
- txready  input  1  sink can accept a word.
- txdata  output  WIDTH  word presented to sink.
- txclk  output  1  one-cycle transfer strobe.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  CW  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset (asynchronous assert, any state, including mid-transfer):
  - FSM to IDLE; read/write pointers to 0; count=0; empty=1; full=0.
  - txdata=0; txclk=0; overflow=0.
  - No partial strobe may survive reset.
- FIFO:
  - Circular buffer; pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0.
  - count tracks occupancy in a separate register.
- Write: when wr_en=1 and (full=0, or a pop occurs in the same cycle), store wr_data at the write pointer; the write pointer increments next edge.
- Dropped write: wr_en=1 while full=1 with no same-cycle pop.
  - Data is dropped and FIFO unchanged.
  - overflow is set on the next edge.
- overflow:
  - Remains set until clr_ovf=1 or reset.
  - If clr_ovf and a new dropped write coincide, set wins.
- Pop: occurs only on an FSM transition into SETUP.
  - Head word is loaded into the txdata register; read pointer increments.
- count: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
- Simultaneous push and pop on an empty FIFO: not possible, because pop requires empty=0 in that cycle. The pushed word is visible to the FSM on the following cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: txclk=0. If txready=1 and empty=0, pop -> SETUP; else stay.
  - SETUP: txdata holds the popped word; txclk=0; -> STROBE unconditionally.
  - STROBE: txclk=1 for exactly this cycle; txdata stable; -> HOLD unconditionally, regardless of txready.
  - HOLD: txclk=0; txdata stable.
    - If txready=1 and empty=0: pop -> SETUP (back-to-back, 3 cycles per word).
    - Otherwise -> IDLE.
- txdata: changes only on entry to SETUP or on reset. Otherwise it holds the last transmitted word, and retains it in IDLE.
- txready: sampled only in IDLE and HOLD. Deassertion during SETUP/STROBE does not abort the transfer once it has started.
- Latency: word written at edge N with FIFO empty, FSM in IDLE and txready=1:
  - Popped at edge N+1 (SETUP).
  - txclk high during cycle after edge N+2.
  - FSM returns to IDLE or SETUP at edge N+4.
- Throughput: with txready held high and FIFO non-empty, one word every 3 cycles.
- Registered outputs: txclk, txdata, count and overflow are registered. full and empty are decoded from count.

Test Plan:
- Reset state and single word: reset pulse, then write 8'hA5 with txready=1.
  - Before the write: txdata=0, txclk=0, count=0, empty=1, overflow=0.
  - After the write: txclk high for exactly 1 cycle, 3 cycles after the write edge, with txdata=8'hA5 one cycle before, during and one cycle after; count returns to 0.
- Fill and overflow: txready=0, write 17 words 0x00..0x10 (DEPTH=16).
  - count=16, full=1, overflow=1; word 0x10 is absent.
  - Raising txready emits 0x00..0x0F in order, one strobe every 3 cycles.
  - overflow stays 1 until clr_ovf=1, then reads 0.
- Full with simultaneous pop: FIFO full, FSM in HOLD with txready=1; write 0x55 on the popping edge.
  - Write accepted; count stays 16; overflow remains 0; 0x55 is the last word emitted.
- Backpressure: 4 words queued; txready drops during STROBE of word 1.
  - Word 1 completes its strobe; no further strobe occurs while txready=0.
  - Words 2..4 are emitted after txready returns to 1.
- Pointer wrap: 40 words streamed with WIDTH=12 and DEPTH=4, interleaving writes and pops.
  - All 40 values appear on txdata in order, with no loss or duplication.
- Reset mid-transfer: assert reset during STROBE.
  - txclk falls immediately (asynchronously); count=0.
  - After release, no strobe occurs until a new word is written.
